iter_divider: RTL and testbench



---
 rtl/alu_pkg.sv | 37 +++
 rtl/div_step.sv | 35 +++
 rtl/iter_divider.sv | 165 ++++++++++++++++
 tb/tb_iter_divider.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: condition-code bit positions, divider states, DIV/DIVU/MOD opcodes.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_pkg;

  // Bit positions inside the 4-bit {N, Z, C, V} condition code.
  localparam int CC_N  = 3;
  localparam int CC_Z  = 2;
  localparam int CC_C  = 1;
  localparam int CC_DZ = CC_C;  // carry slot doubles as divide-by-zero
  localparam int CC_V  = 0;

  // Divide-class opcodes. The ALU decodes these into is_signed / is_mod.
  localparam logic [3:0] OP_DIV  = 4'hA;  // signed quotient
  localparam logic [3:0] OP_DIVU = 4'hB;  // unsigned quotient
  localparam logic [3:0] OP_MOD  = 4'hC;  // signed remainder

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

  // Assemble a condition code from its individual flags.
  function automatic logic [3:0] make_cc(input logic n, input logic z,
                                         input logic dz, input logic v);
    logic [3:0] cc;
    cc        = 4'b0000;
    cc[CC_N]  = n;
    cc[CC_Z]  = z;
    cc[CC_DZ] = dz;
    cc[CC_V]  = v;
    return cc;
  endfunction

endpackage

// File: rtl/div_step.sv
// Restoring shift-subtract core: BITS_PER_CYCLE quotient bits per evaluation.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to register the result.
module div_step #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] div_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  // One extra remainder bit: the shifted partial remainder can reach 2*divisor-1.
  logic [WIDTH:0]   r;
  logic [WIDTH-1:0] q;

  // Unrolled chain of restoring steps; dividend bits enter from the quotient MSB.
  always_comb begin
    r = {1'b0, rem_i};
    q = quo_i;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      r = {r[WIDTH-1:0], q[WIDTH-1]};
      q = {q[WIDTH-2:0], 1'b0};
      if (r >= {1'b0, div_i}) begin
        r    = r - {1'b0, div_i};
        q[0] = 1'b1;
      end
    end
    rem_o = r[WIDTH-1:0];
    quo_o = q;
  end

endmodule

// File: rtl/iter_divider.sv
// Iterative signed/unsigned divider returning quotient or remainder plus {N,Z,DZ,V}.
// Latency: WIDTH/BITS_PER_CYCLE + 1 edges after accept; 1 edge for divide-by-zero.
// Backpressure: results hold in DONE until out_ready; in_ready only in IDLE.
module iter_divider
  import alu_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] valA,
  input  logic [WIDTH-1:0] valB,
  input  logic             is_signed,
  input  logic             is_mod,
  input  logic             abort,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] valE,
  output logic [3:0]       alucc
);

  localparam int STEPS = WIDTH / BITS_PER_CYCLE;
  localparam int CNT_W = $clog2(STEPS + 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

  div_state_t       state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;   // dividend shifting out, quotient shifting in
  logic [WIDTH-1:0] div_q, div_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sgn_q, sgn_d;
  logic             mod_q, mod_d;
  logic             neg_a_q, neg_a_d;
  logic             neg_b_q, neg_b_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] vale_q, vale_d;
  logic [3:0]       alucc_q, alucc_d;

  logic [WIDTH-1:0] step_rem, step_quo;
  logic [WIDTH-1:0] q_fix, r_fix, res;
  logic             b_zero, a_neg, b_neg, ovf;

  div_step #(
    .WIDTH          (WIDTH),
    .BITS_PER_CYCLE (BITS_PER_CYCLE)
  ) u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .div_i (div_q),
    .rem_o (step_rem),
    .quo_o (step_quo)
  );

  // Next-state and datapath update; abort overrides everything and leaves results alone.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    sgn_d   = sgn_q;
    mod_d   = mod_q;
    neg_a_d = neg_a_q;
    neg_b_d = neg_b_q;
    dz_d    = dz_q;
    vale_d  = vale_q;
    alucc_d = alucc_q;
    b_zero  = (valB == '0);
    a_neg   = is_signed & valA[WIDTH-1];
    b_neg   = is_signed & valB[WIDTH-1];
    q_fix   = (neg_a_q ^ neg_b_q) ? -quo_q : quo_q;
    r_fix   = neg_a_q ? -rem_q : rem_q;
    // Only MIN / -1 yields a quotient magnitude of 2^(W-1) with like signs.
    ovf     = sgn_q & ~mod_q & ~(neg_a_q ^ neg_b_q) & quo_q[WIDTH-1];
    res     = '0;

    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            sgn_d   = is_signed;
            mod_d   = is_mod;
            neg_a_d = a_neg;
            neg_b_d = b_neg;
            dz_d    = b_zero;
            rem_d   = '0;
            cnt_d   = '0;
            // Divide-by-zero keeps the raw dividend so MOD can return it unchanged.
            quo_d   = (a_neg && !b_zero) ? -valA : valA;
            div_d   = b_neg ? -valB : valB;
            // Divide-by-zero skips CALC; FIX forms its result one edge later.
            state_d = b_zero ? FIX : CALC;
          end
        end
        CALC: begin
          rem_d = step_rem;
          quo_d = step_quo;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_STEP) begin
            state_d = FIX;
          end
        end
        FIX: begin
          if (dz_q) begin
            res     = mod_q ? quo_q : '1;
            alucc_d = make_cc(res[WIDTH-1], ~|res, 1'b1, 1'b0);
          end else begin
            res     = mod_q ? r_fix : q_fix;
            alucc_d = make_cc(res[WIDTH-1], ~|res, 1'b0, ovf);
          end
          vale_d  = res;
          state_d = DONE;
        end
        DONE: begin
          if (out_ready) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rem_q   <= '0;
      quo_q   <= '0;
      div_q   <= '0;
      cnt_q   <= '0;
      sgn_q   <= 1'b0;
      mod_q   <= 1'b0;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
      dz_q    <= 1'b0;
      vale_q  <= '0;
      alucc_q <= 4'b0000;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      sgn_q   <= sgn_d;
      mod_q   <= mod_d;
      neg_a_q <= neg_a_d;
      neg_b_q <= neg_b_d;
      dz_q    <= dz_d;
      vale_q  <= vale_d;
      alucc_q <= alucc_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign valE      = vale_q;
  assign alucc     = alucc_q;

endmodule

// File: tb/tb_iter_divider.sv
// Self-checking bench: two divider instances (1 and 4 bits/cycle) driven in lockstep.
// Latency: checked per instance against WIDTH/BPC + 1 (1 for divide-by-zero).
// Backpressure: out_ready held low in DONE; stability and in_ready checked.
module tb_iter_divider;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         is_signed = 1'b0;
  logic         is_mod = 1'b0;
  logic         abort = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] valA = '0;
  logic [W-1:0] valB = '0;

  logic         in_ready1, out_valid1, in_ready4, out_valid4;
  logic [W-1:0] valE1, valE4;
  logic [3:0]   alucc1, alucc4;

  int n_cmp = 0;
  int n_fail = 0;

  logic [W-1:0] last_e1, last_e4;
  logic [3:0]   last_c1, last_c4;

  always #5 clk = ~clk;

  iter_divider #(.WIDTH(W), .BITS_PER_CYCLE(1)) u_div1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .valA(valA), .valB(valB), .is_signed(is_signed), .is_mod(is_mod),
    .abort(abort), .out_valid(out_valid1), .out_ready(out_ready),
    .valE(valE1), .alucc(alucc1)
  );

  iter_divider #(.WIDTH(W), .BITS_PER_CYCLE(4)) u_div4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
    .valA(valA), .valB(valB), .is_signed(is_signed), .is_mod(is_mod),
    .abort(abort), .out_valid(out_valid4), .out_ready(out_ready),
    .valE(valE4), .alucc(alucc4)
  );

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic; SV / and % truncate toward zero.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic s, input logic m,
                                output logic [W-1:0] res, output logic [3:0] cc);
    longint sa, sb, q, r;
    logic   v;
    v = 1'b0;
    if (b == 0) begin
      res = m ? a : {W{1'b1}};
    end else if (!s) begin
      res = m ? (a % b) : (a / b);
    end else begin
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      q   = sa / sb;
      r   = sa % sb;
      res = m ? r[W-1:0] : q[W-1:0];
      v   = !m && (q > 64'sd2147483647);
    end
    cc = {res[W-1], (res == 0), (b == 0), v};
  endfunction

  // Drive one request, measure both latencies, check results, hold, then handshake.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic s, input logic m, input int hold, input string nm);
    logic [W-1:0] er;
    logic [3:0]   ec;
    int lat1, lat4, exp1, exp4;
    model(a, b, s, m, er, ec);
    exp1 = (b == 0) ? 1 : W + 1;
    exp4 = (b == 0) ? 1 : W / 4 + 1;
    @(negedge clk);
    check($sformatf("%s in_ready1", nm), W'(in_ready1), W'(1));
    check($sformatf("%s in_ready4", nm), W'(in_ready4), W'(1));
    valA = a; valB = b; is_signed = s; is_mod = m; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    valA = $urandom; valB = $urandom; is_signed = $urandom_range(0, 1); is_mod = $urandom_range(0, 1);
    lat1 = -1; lat4 = -1;
    for (int e = 1; e <= W + 8 && (lat1 < 0 || lat4 < 0); e++) begin
      @(posedge clk); #1;
      if (out_valid1 && lat1 < 0) lat1 = e;
      if (out_valid4 && lat4 < 0) lat4 = e;
    end
    check($sformatf("%s lat1", nm), W'(lat1), W'(exp1));
    check($sformatf("%s lat4", nm), W'(lat4), W'(exp4));
    check($sformatf("%s valE1", nm), valE1, er);
    check($sformatf("%s alucc1", nm), W'(alucc1), W'(ec));
    check($sformatf("%s valE4", nm), valE4, er);
    check($sformatf("%s alucc4", nm), W'(alucc4), W'(ec));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check($sformatf("%s hold%0d valE1", nm, i), valE1, er);
      check($sformatf("%s hold%0d ctl1", nm, i), W'({alucc1, out_valid1, in_ready1}), W'({ec, 2'b10}));
      check($sformatf("%s hold%0d ctl4", nm, i), W'({alucc4, out_valid4, in_ready4}), W'({ec, 2'b10}));
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check($sformatf("%s post ctl1", nm), W'({alucc1, out_valid1, in_ready1}), W'({ec, 2'b01}));
    check($sformatf("%s post ctl4", nm), W'({alucc4, out_valid4, in_ready4}), W'({ec, 2'b01}));
    check($sformatf("%s post valE4", nm), valE4, er);
    last_e1 = er; last_e4 = er; last_c1 = ec; last_c4 = ec;
  endtask

  // Watch for a number of cycles and count any out_valid that appears.
  task automatic watch_quiet(input int cycles, input string nm);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (out_valid1 || out_valid4) seen++;
    end
    check($sformatf("%s quiet", nm), W'(seen), W'(0));
  endtask

  initial begin
    logic [W-1:0] ra, rb, er;
    logic [3:0]   ec;
    int           sel;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst valE1", valE1, '0);
    check("rst ctl1", W'({alucc1, out_valid1, in_ready1}), W'(6'b000001));
    check("rst valE4", valE4, '0);
    check("rst ctl4", W'({alucc4, out_valid4, in_ready4}), W'(6'b000001));

    // Directed cases; the first one exercises back-pressure, the rest run back-to-back.
    do_op(32'd100, 32'd7, 1'b0, 1'b0, 10, "divu100_7");
    do_op(32'd100, 32'd7, 1'b0, 1'b1, 0, "modu100_7");
    do_op(-32'sd7, 32'd2, 1'b1, 1'b0, 0, "div-7_2");
    do_op(-32'sd7, 32'd2, 1'b1, 1'b1, 0, "mod-7_2");
    do_op(32'd7, -32'sd2, 1'b1, 1'b0, 0, "div7_-2");
    do_op(32'd7, -32'sd2, 1'b1, 1'b1, 0, "mod7_-2");
    do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 0, "ovf_div");
    do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 0, "ovf_mod");
    do_op(32'h8000_0000, 32'd1, 1'b1, 1'b0, 0, "min_div1");
    do_op(32'd5, 32'd0, 1'b0, 1'b0, 0, "dz_divu");
    do_op(32'd5, 32'd0, 1'b0, 1'b1, 0, "dz_mod");
    do_op(-32'sd9, 32'd0, 1'b1, 1'b1, 0, "dz_smod");
    do_op(-32'sd9, 32'd0, 1'b1, 1'b0, 0, "dz_sdiv");
    do_op(32'd0, 32'd5, 1'b0, 1'b0, 0, "zero_div");
    do_op(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 0, "max_divu1");

    // Abort during CALC (1-bit instance) and during DONE (4-bit instance).
    model(32'd1000, 32'd3, 1'b0, 1'b0, er, ec);
    @(negedge clk);
    valA = 32'd1000; valB = 32'd3; is_signed = 1'b0; is_mod = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (12) @(posedge clk);
    @(negedge clk);
    abort = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    check("abort ctl1", W'({out_valid1, in_ready1}), W'(2'b01));
    check("abort ctl4", W'({out_valid4, in_ready4}), W'(2'b01));
    check("abort valE1 kept", valE1, last_e1);
    check("abort alucc1 kept", W'(alucc1), W'(last_c1));
    check("abort valE4", valE4, er);
    check("abort alucc4", W'(alucc4), W'(ec));
    watch_quiet(W + 6, "abort");
    last_e4 = er; last_c4 = ec;

    // Reset mid-CALC discards the operation.
    @(negedge clk);
    valA = 32'd12345; valB = 32'd17; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk); rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("mrst valE1", valE1, '0);
    check("mrst ctl1", W'({alucc1, out_valid1, in_ready1}), W'(6'b000001));
    check("mrst valE4", valE4, '0);
    check("mrst ctl4", W'({alucc4, out_valid4, in_ready4}), W'(6'b000001));
    watch_quiet(W + 6, "mrst");

    // Randomized operands with biased divisors.
    for (int n = 0; n < 40; n++) begin
      ra  = $urandom;
      sel = $urandom_range(0, 5);
      case (sel)
        0: rb = '0;
        1: rb = W'($urandom_range(1, 15));
        2: rb = -W'($urandom_range(1, 15));
        3: rb = $urandom;
        4: rb = $urandom >> $urandom_range(0, 31);
        default: begin rb = 32'hFFFF_FFFF; ra = 32'h8000_0000; end
      endcase
      if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
      do_op(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            $urandom_range(0, 2), $sformatf("rnd%0d", n));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
